memory_stage: RTL

Pipeline stage between execute and writeback. It performs data-memory loads and stores using the effective address computed upstream, and sign- or zero-extends load data. It forwards the result, with the unchanged instruction flags, to `writeback_stage` over the same stall/done handshake used by every stage. Non-memory instructions pass through with one cycle of latency.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/load_align.sv | 33 +++
 rtl/memory_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage state encoding and load/store funct3 codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half from an aligned read word and sign/zero-extends it.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (a_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_BYTE:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BYTE_U: data_o = {24'd0, byte_sel};
      F3_HALF:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_HALF_U: data_o = {16'd0, half_sel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory loads/stores and forwards results
// to writeback over the stall/done handshake.
module memory_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH              = 32,
  parameter int DATA_WIDTH              = 32,
  parameter int NUM_REGISTERS           = 32,
  parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                               clk,
  input  logic                               rst,

  output logic                               stall_prev,
  input  logic                               prev_done,
  input  logic                               next_stall,
  output logic                               done_next,

  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               program_count_valid_in,
  input  logic                               register_arith_in,
  input  logic                               immediate_arith_in,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic                               branch_in,
  input  logic                               jal_in,
  input  logic                               jalr_in,
  input  logic                               lui_in,
  input  logic                               auipc_in,
  input  logic                               system_in,
  input  logic                               opcode_legal_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [2:0]                         funct3_in,
  input  logic [31:0]                        store_data_in,

  output logic [ADDR_WIDTH-1:0]              program_count_out,
  output logic                               program_count_valid_out,
  output logic                               register_arith_out,
  output logic                               immediate_arith_out,
  output logic                               load_out,
  output logic                               store_out,
  output logic                               branch_out,
  output logic                               jal_out,
  output logic                               jalr_out,
  output logic                               lui_out,
  output logic                               auipc_out,
  output logic                               system_out,
  output logic                               opcode_legal_out,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic [DATA_WIDTH-1:0]              result_data_out,
  output logic                               result_data_valid_out,

  output logic                               mem_req,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_write,
  output logic [31:0]                        mem_wdata,
  output logic [3:0]                         mem_wstrb,
  input  logic                               mem_ack,
  input  logic [31:0]                        mem_rdata
);

  mem_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]              pc_q;
  logic                               pc_valid_q;
  logic [10:0]                        flags_q;
  logic [REGISTER_INDEXING_WIDTH-1:0] wr_q;
  logic                               wr_valid_q;
  logic [DATA_WIDTH-1:0]              result_q;
  logic                               result_valid_q;
  logic [2:0]                         funct3_q;
  logic [31:0]                        wdata_q;
  logic                               write_q;
  logic [3:0]                         wstrb_q;

  logic        transfer_next, transfer_prev, capture, access_done;
  logic        is_mem, access_ok;
  logic [1:0]  lane;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] load_word;

  assign done_next     = !rst && (state_q == HOLD);
  assign transfer_next = done_next && !next_stall;
  assign stall_prev    = rst || ((state_q != EMPTY) && !transfer_next);
  assign transfer_prev = prev_done && !stall_prev;
  assign capture       = ((state_q == EMPTY) || transfer_next) && transfer_prev;
  assign access_done   = !rst && (state_q == ACCESS) && mem_ack;

  // Size decode: legality/alignment, lane strobes and replicated store data.
  always_comb begin
    is_mem    = load_in || store_in;
    lane      = result_data_in[1:0];
    access_ok = 1'b0;
    strb_d    = '0;
    wdata_d   = store_data_in;
    case (funct3_in)
      F3_BYTE: begin
        access_ok = 1'b1;
        strb_d    = 4'b0001 << lane;
        wdata_d   = {4{store_data_in[7:0]}};
      end
      F3_BYTE_U: begin
        access_ok = load_in;
        strb_d    = 4'b0001 << lane;
      end
      F3_HALF: begin
        access_ok = !lane[0];
        strb_d    = 4'b0011 << lane;
        wdata_d   = {2{store_data_in[15:0]}};
      end
      F3_HALF_U: begin
        access_ok = load_in && !lane[0];
        strb_d    = 4'b0011 << lane;
      end
      F3_WORD: begin
        access_ok = (lane == 2'd0);
        strb_d    = 4'b1111;
      end
      default: access_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == EMPTY) || transfer_next) begin
      if (capture) state_d = (is_mem && access_ok) ? ACCESS : HOLD;
      else         state_d = EMPTY;
    end else if (access_done) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      write_q <= 1'b0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        write_q <= store_in && !load_in && access_ok;
        wstrb_q <= (store_in && !load_in && access_ok) ? strb_d : 4'b0000;
      end
    end
  end

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .a_i      (result_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_word)
  );

  // Payload is not reset; it is only meaningful while done_next is high.
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q           <= program_count_in;
      pc_valid_q     <= program_count_valid_in;
      flags_q        <= {register_arith_in, immediate_arith_in, load_in, store_in,
                         branch_in, jal_in, jalr_in, lui_in, auipc_in, system_in,
                         opcode_legal_in};
      wr_q           <= write_register_in;
      wr_valid_q     <= write_register_valid_in;
      result_q       <= result_data_in;
      result_valid_q <= result_data_valid_in && (!is_mem || access_ok);
      funct3_q       <= funct3_in;
      wdata_q        <= wdata_d;
    end else if (access_done && !write_q) begin
      result_q       <= load_word;
    end
  end

  assign program_count_out        = pc_q;
  assign program_count_valid_out  = pc_valid_q;
  assign {register_arith_out, immediate_arith_out, load_out, store_out,
          branch_out, jal_out, jalr_out, lui_out, auipc_out, system_out,
          opcode_legal_out}       = flags_q;
  assign write_register_out       = wr_q;
  assign write_register_valid_out = wr_valid_q;
  assign result_data_out          = result_q;
  assign result_data_valid_out    = result_valid_q;

  assign mem_req   = !rst && (state_q == ACCESS);
  assign mem_addr  = {result_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_write = write_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule
